unified_sram_arbiter: RTL and testbench

Shares one single-port synchronous SRAM between the instruction-fetch port and the data (MEM-stage) port of the pipelined CPU. Each cycle it grants at most one requester and drives the SRAM with that requester's access. One cycle later it steers the read data back to whichever port issued the read. The data port has fixed priority over fetch, and a bounded-starvation counter guarantees that fetch still makes forward progress.

---
 rtl/cpu_mem_pkg.sv | 14 +
 rtl/arb_starve_cnt.sv | 29 ++
 rtl/unified_sram_arbiter.sv | 94 +++++++++
 tb/tb_unified_sram_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and widths for the CPU memory subsystem.
// Owner encodings tag which port an in-flight SRAM read belongs to.
package cpu_mem_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the fetch port has been denied.
// at_limit tells the arbiter to let fetch win the next contention.
module arb_starve_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         at_limit
);

  logic [W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != limit)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == limit);

endmodule

// File: rtl/unified_sram_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and the data port.
// Data has fixed priority; fetch wins once it has been denied STARVE_LIMIT cycles in a row.
module unified_sram_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_req,
  input  logic [XLEN-1:0] inst_addr,
  output logic            inst_gnt,
  output logic            inst_rvalid,
  output logic [XLEN-1:0] inst_rdata,
  input  logic            data_req,
  input  logic [BE_W-1:0] data_we,
  input  logic [XLEN-1:0] data_addr,
  input  logic [XLEN-1:0] data_wdata,
  output logic            data_gnt,
  output logic            data_rvalid,
  output logic [XLEN-1:0] data_rdata,
  output logic            sram_en,
  output logic [BE_W-1:0] sram_we,
  output logic [XLEN-1:0] sram_addr,
  output logic [XLEN-1:0] sram_wdata,
  input  logic [XLEN-1:0] sram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  owner_t owner, owner_next;
  logic   starved;

  arb_starve_cnt #(.W(CNT_W)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (inst_req & ~inst_gnt),
    .clr      (inst_gnt | ~inst_req),
    .limit    (CNT_W'(STARVE_LIMIT)),
    .at_limit (starved)
  );

  // Grants are suppressed while reset is held so the SRAM sees no access.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (!reset) begin
      if (data_req && !(inst_req && starved)) begin
        data_gnt = 1'b1;
      end else if (inst_req) begin
        inst_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    sram_en    = inst_gnt | data_gnt;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (inst_gnt) begin
      sram_addr = inst_addr;
    end else if (data_gnt) begin
      sram_we    = data_we;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end
  end

  // Writes leave no response behind; only reads claim the return slot.
  always_comb begin
    owner_next = OWN_NONE;
    if (inst_gnt) begin
      owner_next = OWN_INST;
    end else if (data_gnt && (data_we == '0)) begin
      owner_next = OWN_DATA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_next;
    end
  end

  assign inst_rvalid = (owner == OWN_INST);
  assign data_rvalid = (owner == OWN_DATA);
  assign inst_rdata  = sram_rdata;
  assign data_rdata  = sram_rdata;

endmodule

// File: tb/tb_unified_sram_arbiter.sv
// Randomized bench for unified_sram_arbiter with a transaction-level reference model,
// a behavioural SRAM, and literal expectations for the directed scenarios.
module tb_unified_sram_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_gnt, inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic [3:0]  data_we = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata = '0;

  unified_sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_gnt    (inst_gnt),
    .inst_rvalid (inst_rvalid),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents: written words live here, untouched words read as a hash of their address.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_1234;
  endfunction

  always @(posedge clk) begin
    if (sram_en && sram_we == 4'b0000) sram_rdata <= rd(sram_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: who owes a response next cycle, its word, and how long fetch has waited.
  int          m_owner  = 0;   // 0 none, 1 inst, 2 data
  logic [31:0] m_word   = '0;
  int          m_denied = 0;
  logic        g_inst = 1'b0, g_data = 1'b0;

  task automatic compare();
    int          w;
    logic [31:0] ea, ew, word;
    logic [3:0]  ewe;
    if (reset) begin
      m_owner  = 0;
      m_denied = 0;
      g_inst   = 1'b0;
      g_data   = 1'b0;
      check("rst_inst_gnt", 32'(inst_gnt), 0);
      check("rst_data_gnt", 32'(data_gnt), 0);
      check("rst_sram_en", 32'(sram_en), 0);
      check("rst_sram_we", 32'(sram_we), 0);
      check("rst_inst_rvalid", 32'(inst_rvalid), 0);
      check("rst_data_rvalid", 32'(data_rvalid), 0);
    end else begin
      check("inst_rvalid", 32'(inst_rvalid), 32'(m_owner == 1));
      check("data_rvalid", 32'(data_rvalid), 32'(m_owner == 2));
      if (m_owner == 1) check("inst_rdata", inst_rdata, m_word);
      if (m_owner == 2) check("data_rdata", data_rdata, m_word);

      w = 0;
      if (inst_req && data_req) w = (m_denied >= LIMIT) ? 1 : 2;
      else if (inst_req)        w = 1;
      else if (data_req)        w = 2;

      ea = '0; ew = '0; ewe = '0;
      if (w == 1) ea = inst_addr;
      if (w == 2) begin ea = data_addr; ew = data_wdata; ewe = data_we; end
      check("inst_gnt", 32'(inst_gnt), 32'(w == 1));
      check("data_gnt", 32'(data_gnt), 32'(w == 2));
      check("sram_en", 32'(sram_en), 32'(w != 0));
      check("sram_addr", sram_addr, ea);
      check("sram_we", 32'(sram_we), 32'(ewe));
      check("sram_wdata", sram_wdata, ew);

      if (w == 2 && data_we != 4'b0000) begin
        word = rd(data_addr);
        for (int b = 0; b < 4; b++)
          if (data_we[b]) word[8*b +: 8] = data_wdata[8*b +: 8];
        mem[data_addr] = word;
      end
      m_word   = rd(ea);
      m_owner  = (w == 1) ? 1 : (w == 2 && data_we == 4'b0000) ? 2 : 0;
      m_denied = (inst_req && w != 1) ? ((m_denied < LIMIT) ? m_denied + 1 : LIMIT) : 0;
      g_inst   = (w == 1);
      g_data   = (w == 2);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  initial begin
    // Reset state
    sample();
    check("init_inst_rvalid", 32'(inst_rvalid), 0);
    check("init_sram_en", 32'(sram_en), 0);
    advance();
    reset = 1'b0;
    cycle();

    // Fetch alone
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    sample();
    check("lit_inst_gnt", 32'(inst_gnt), 1);
    check("lit_inst_addr", sram_addr, 32'h1C00_0000);
    check("lit_inst_we", 32'(sram_we), 0);
    advance();
    inst_req = 1'b0;
    sample();
    check("lit_inst_rvalid", 32'(inst_rvalid), 1);
    check("lit_inst_rdata", inst_rdata, 32'h465A_1234);
    advance();

    // Contention: data read wins, fetch holds and follows
    inst_req = 1'b1; inst_addr = 32'h40;
    data_req = 1'b1; data_we = 4'b0000; data_addr = 32'h1000;
    sample();
    check("lit_both_data_gnt", 32'(data_gnt), 1);
    check("lit_both_inst_gnt", 32'(inst_gnt), 0);
    advance();
    data_req = 1'b0;
    sample();
    check("lit_data_rvalid", 32'(data_rvalid), 1);
    check("lit_no_inst_rvalid", 32'(inst_rvalid), 0);
    advance();
    inst_req = 1'b0;
    cycle();

    // Partial write, then read it back
    data_req = 1'b1; data_we = 4'b0011; data_addr = 32'h2000; data_wdata = 32'hDEAD_BEEF;
    sample();
    check("lit_wr_we", 32'(sram_we), 32'h3);
    check("lit_wr_wdata", sram_wdata, 32'hDEAD_BEEF);
    advance();
    data_req = 1'b0; data_we = 4'b0000;
    sample();
    check("lit_wr_no_inst_rvalid", 32'(inst_rvalid), 0);
    check("lit_wr_no_data_rvalid", 32'(data_rvalid), 0);
    advance();
    data_req = 1'b1;
    cycle();
    data_req = 1'b0;
    sample();
    check("lit_rb_rdata", data_rdata, 32'h5A5A_BEEF);
    advance();

    // Continuous contention: fetch wins every (LIMIT+1)th cycle
    inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h1004;
    for (int i = 0; i < 10; i++) begin
      sample();
      check("lit_starve_inst_gnt", 32'(inst_gnt), 32'(i == 4 || i == 9));
      check("lit_starve_data_gnt", 32'(data_gnt), 32'(i != 4 && i != 9));
      advance();
    end
    inst_req = 1'b0; data_req = 1'b0;
    cycle();

    // Alternating single requesters
    for (int i = 0; i < 8; i++) begin
      inst_req  = (i % 2 == 0);
      data_req  = (i % 2 == 1);
      inst_addr = 32'(i * 4);
      data_addr = 32'h100 + 32'(i * 4);
      sample();
      if (i > 0) check("lit_alt_inst_rvalid", 32'(inst_rvalid), 32'(i % 2 == 1));
      advance();
    end
    inst_req = 1'b0; data_req = 1'b0;
    cycle();

    // Reset pulsed with a read outstanding and the starvation count part-way up
    inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h1008;
    for (int i = 0; i < 3; i++) cycle();
    #1 reset = 1'b1;
    #1;
    check("lit_rst_data_rvalid", 32'(data_rvalid), 0);
    check("lit_rst_sram_en", 32'(sram_en), 0);
    check("lit_rst_data_gnt", 32'(data_gnt), 0);
    sample();
    advance();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("lit_post_rst_inst_gnt", 32'(inst_gnt), 32'(i == 4));
      advance();
    end
    inst_req = 1'b0; data_req = 1'b0;
    cycle();

    // Random traffic; requesters hold until granted
    for (int n = 0; n < 3000; n++) begin
      if (!inst_req || g_inst) begin
        inst_req  = ($urandom_range(0, 99) < 60);
        inst_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!data_req || g_data) begin
        data_req   = ($urandom_range(0, 99) < 80);
        data_addr  = 32'($urandom_range(0, 15)) << 2;
        data_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
        data_wdata = $urandom;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
